// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard with bypass selection and per-register latency countdown.
// Outputs are combinational from state and inputs; the issue gate is the only backpressure.
module hazard_scoreboard #(
  parameter int ARCH_BITS      = 32,
  parameter int REG_IDX_BITS   = 5,
  parameter int NUM_SRC        = 2,
  parameter int NUM_PROD       = 8,
  parameter int LAT_BITS       = 3,
  parameter int ZERO_REG_EN    = 1,
  parameter int STALL_CNT_BITS = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_SRC-1:0]             src_en,
  input  logic [NUM_SRC*REG_IDX_BITS-1:0] src_idx,
  input  logic [NUM_PROD-1:0]            prod_valid,
  input  logic [NUM_PROD-1:0]            prod_we,
  input  logic [NUM_PROD*REG_IDX_BITS-1:0] prod_dst,
  input  logic [NUM_PROD*ARCH_BITS-1:0]  prod_data,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  logic [REG_IDX_BITS-1:0]        issue_dst,
  input  logic [LAT_BITS-1:0]            issue_lat,
  output logic [NUM_SRC-1:0]             src_hit,
  output logic [NUM_SRC*ARCH_BITS-1:0]   src_data,
  output logic [NUM_SRC-1:0]             src_block,
  output logic                           issue_stall,
  output logic                           issue_fire,
  output logic [STALL_CNT_BITS-1:0]      stall_count
);

  localparam int NUM_REGS = 1 << REG_IDX_BITS;

  logic [LAT_BITS-1:0] cnt [NUM_REGS];
  logic [LAT_BITS-1:0] lat_eff;
  logic                waw;
  logic                wr_ok;

  // A zero latency still occupies the register for one cycle.
  assign lat_eff = (issue_lat == '0) ? LAT_BITS'(1) : issue_lat;

  always_comb begin
    logic [REG_IDX_BITS-1:0] idx;
    logic                    zero;
    logic                    any_match;
    logic                    found;
    src_hit   = '0;
    src_data  = '1;
    src_block = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx       = src_idx[i*REG_IDX_BITS +: REG_IDX_BITS];
      zero      = (ZERO_REG_EN != 0) && (idx == '0);
      any_match = 1'b0;
      found     = 1'b0;
      // Ascending scan with a found flag gives slot 0 (youngest) priority.
      for (int p = 0; p < NUM_PROD; p++) begin
        if (src_en[i] && !zero && prod_valid[p] &&
            (prod_dst[p*REG_IDX_BITS +: REG_IDX_BITS] == idx)) begin
          any_match = 1'b1;
          if (prod_we[p] && !found) begin
            found = 1'b1;
            src_data[i*ARCH_BITS +: ARCH_BITS] = prod_data[p*ARCH_BITS +: ARCH_BITS];
          end
        end
      end
      src_hit[i]   = found;
      src_block[i] = src_en[i] && !zero && !found && ((cnt[idx] != '0) || any_match);
    end
  end

  // A new write landing no later than the outstanding one would be overwritten out of order.
  assign waw         = issue_valid && issue_we && (cnt[issue_dst] != '0) &&
                       (cnt[issue_dst] >= lat_eff);
  assign issue_stall = issue_valid && !flush && ((|src_block) || waw);
  assign issue_fire  = issue_valid && !flush && !issue_stall;
  assign wr_ok       = issue_fire && issue_we && !((ZERO_REG_EN != 0) && (issue_dst == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && (issue_dst == REG_IDX_BITS'(r))) begin
          cnt[r] <= lat_eff;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (issue_valid && issue_stall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a timestamp-based reference model queues expectations; a negedge monitor checks them.
module tb_hazard_scoreboard;
  localparam int AB = 32;
  localparam int RB = 5;
  localparam int NS = 2;
  localparam int NP = 8;
  localparam int LB = 3;
  localparam int SB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [NS-1:0]      src_en;
  logic [NS*RB-1:0]   src_idx;
  logic [NP-1:0]      prod_valid;
  logic [NP-1:0]      prod_we;
  logic [NP*RB-1:0]   prod_dst;
  logic [NP*AB-1:0]   prod_data;
  logic               issue_valid;
  logic               issue_we;
  logic [RB-1:0]      issue_dst;
  logic [LB-1:0]      issue_lat;
  logic [NS-1:0]      src_hit;
  logic [NS*AB-1:0]   src_data;
  logic [NS-1:0]      src_block;
  logic               issue_stall;
  logic               issue_fire;
  logic [SB-1:0]      stall_count;

  hazard_scoreboard #(
    .ARCH_BITS(AB), .REG_IDX_BITS(RB), .NUM_SRC(NS), .NUM_PROD(NP),
    .LAT_BITS(LB), .ZERO_REG_EN(1), .STALL_CNT_BITS(SB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .src_en(src_en), .src_idx(src_idx),
    .prod_valid(prod_valid), .prod_we(prod_we), .prod_dst(prod_dst), .prod_data(prod_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src_hit(src_hit), .src_data(src_data), .src_block(src_block),
    .issue_stall(issue_stall), .issue_fire(issue_fire), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0]    hit;
    logic [NS*AB-1:0] data;
    logic [NS-1:0]    blk;
    logic             stall;
    logic             fire;
    logic [SB-1:0]    sc;
  } exp_t;

  exp_t q[$];
  int   ready [32];   // absolute cycle at which each register becomes free
  int   cyc;
  int   sc_model;
  int   n_checks;
  int   n_pass;

  function automatic int cnt_of(int r);
    int v;
    v = ready[r] - cyc;
    return (v > 0) ? v : 0;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("src_hit",     64'(src_hit),     64'(e.hit));
        check("src_data",    64'(src_data),    64'(e.data));
        check("src_block",   64'(src_block),   64'(e.blk));
        check("issue_stall", 64'(issue_stall), 64'(e.stall));
        check("issue_fire",  64'(issue_fire),  64'(e.fire));
        check("stall_count", 64'(stall_count), 64'(e.sc));
      end
    end
  end

  task automatic clr();
    flush = 0; src_en = '0; src_idx = '0; prod_valid = '0; prod_we = '0;
    prod_dst = '0; prod_data = '0; issue_valid = 0; issue_we = 0;
    issue_dst = '0; issue_lat = '0;
  endtask

  task automatic step();
    exp_t e;
    int idx, lat, c;
    bit any_m, hit, waw;
    if (rst) begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      sc_model = 0;
    end
    e.hit = '0; e.data = '1; e.blk = '0;
    for (int i = 0; i < NS; i++) begin
      idx = int'(src_idx[i*RB +: RB]);
      any_m = 0; hit = 0;
      for (int p = 0; p < NP; p++) begin
        if (src_en[i] && prod_valid[p] && int'(prod_dst[p*RB +: RB]) == idx) begin
          any_m = 1;
          if (prod_we[p] && !hit) begin
            hit = 1;
            e.data[i*AB +: AB] = prod_data[p*AB +: AB];
          end
        end
      end
      if (idx == 0) begin
        hit = 0; any_m = 0; e.data[i*AB +: AB] = '1;
      end
      e.hit[i] = hit;
      e.blk[i] = src_en[i] && !hit && (cnt_of(idx) > 0 || any_m);
    end
    lat = (issue_lat == 0) ? 1 : int'(issue_lat);
    c = cnt_of(int'(issue_dst));
    waw = issue_valid && issue_we && c > 0 && c >= lat;
    e.stall = !flush && issue_valid && ((|e.blk) || waw);
    e.fire = issue_valid && !flush && !e.stall;
    e.sc = SB'(sc_model);
    q.push_back(e);
    if (!rst) begin
      if (flush) begin
        for (int r = 0; r < 32; r++) ready[r] = 0;
      end else if (e.fire && issue_we && issue_dst != 0) begin
        ready[issue_dst] = cyc + lat + 1;
      end
      if (issue_valid && e.stall && sc_model < (1 << SB) - 1) sc_model++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic fire_to(int dst, int lat);
    clr(); issue_valid = 1; issue_we = 1; issue_dst = RB'(dst); issue_lat = LB'(lat);
    step();
  endtask

  task automatic read_issue(int idx);
    clr(); src_en = 2'b01; src_idx[0 +: RB] = RB'(idx); issue_valid = 1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; sc_model = 0;
    for (int r = 0; r < 32; r++) ready[r] = 0;
    rst = 1; clr();
    @(posedge clk); #1;
    step();
    rst = 0;

    // RAW countdown on r5
    fire_to(5, 3);
    for (int k = 0; k < 4; k++) begin read_issue(5); step(); end

    // bypass priority: slots 2 and 6 both produce r5
    fire_to(5, 2);
    read_issue(5);
    prod_valid[2] = 1; prod_we[2] = 1; prod_dst[2*RB +: RB] = 5; prod_data[2*AB +: AB] = 32'hAAAA;
    prod_valid[6] = 1; prod_we[6] = 1; prod_dst[6*RB +: RB] = 5; prod_data[6*AB +: AB] = 32'hBBBB;
    step();

    // producer visible but result not yet available
    read_issue(7);
    prod_valid[1] = 1; prod_dst[1*RB +: RB] = 7; prod_data[1*AB +: AB] = 32'h1234;
    step();

    // WAW retry on r9, then a read to observe the new countdown
    fire_to(9, 4);
    for (int k = 0; k < 4; k++) begin
      clr(); issue_valid = 1; issue_we = 1; issue_dst = 9; issue_lat = 2; step();
    end
    for (int k = 0; k < 3; k++) begin read_issue(9); issue_valid = 0; step(); end

    // flush with a blocked operand
    fire_to(4, 3);
    read_issue(4); flush = 1; step();
    read_issue(4); step();

    // saturating stall counter via a never-ready producer
    for (int k = 0; k < 20; k++) begin
      read_issue(11); prod_valid[0] = 1; prod_dst[0 +: RB] = 11; step();
    end

    // zero register is never busy
    fire_to(0, 5);
    for (int k = 0; k < 2; k++) begin
      read_issue(0); prod_valid[3] = 1; prod_dst[3*RB +: RB] = 0; step();
    end

    // asynchronous reset mid-countdown
    fire_to(3, 4);
    read_issue(3); issue_valid = 0; rst = 1; step();
    rst = 0; read_issue(3); step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      clr();
      rst = (n == 200);
      flush = ($urandom_range(0, 15) == 0);
      src_en = NS'($urandom);
      for (int i = 0; i < NS; i++) src_idx[i*RB +: RB] = RB'($urandom_range(0, 7));
      prod_valid = NP'($urandom);
      prod_we = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        prod_dst[p*RB +: RB] = RB'($urandom_range(0, 7));
        prod_data[p*AB +: AB] = $urandom;
      end
      issue_valid = !rst && ($urandom_range(0, 3) != 0);
      issue_we = 1'($urandom);
      issue_dst = RB'($urandom_range(0, 7));
      issue_lat = LB'($urandom_range(0, 7));
      step();
    end
    rst = 0; clr();

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
